// File: rtl/sram_1rw1r_32_256_8_ctrl.sv
// Valid/ready front end for the 1RW1R 32x256 OpenRAM macro: registered macro pins,
// a two-stage read tracker and a credit-checked response FIFO per port.

module sram_1rw1r_32_256_8_rsp #(
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_issue_i,
    input  logic [DATA_WIDTH-1:0] dout_i,
    input  logic                  rready_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  credit_o
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    // vld_pipe_q[0]: macro samples the read next edge; vld_pipe_q[1]: dout is valid, capture now
    logic [1:0]                           vld_pipe_q, vld_pipe_d;
    logic [RSP_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [PW-1:0]                        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                        cnt_q, cnt_d;
    logic [CW:0]                          used;
    logic                                 push, pop;

    assign push       = vld_pipe_q[1];
    assign pop        = rvalid_o & rready_i;
    assign vld_pipe_d = {vld_pipe_q[0], rd_issue_i};
    assign cnt_d      = cnt_q + CW'(push) - CW'(pop);

    // Reads in flight already own a FIFO slot, so a capture can never overflow.
    assign used     = (CW+1)'(cnt_q) + (CW+1)'(vld_pipe_q[0]) + (CW+1)'(vld_pipe_q[1]);
    assign credit_o = used < (CW+1)'(RSP_DEPTH);
    assign rvalid_o = cnt_q != '0;
    assign rdata_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= dout_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

module sram_1rw1r_32_256_8_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic                  a_we_i,
    input  logic [NUM_WMASKS-1:0] a_wmask_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic                  a_rvalid_o,
    input  logic                  a_rready_i,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    output logic                  b_rvalid_o,
    input  logic                  b_rready_i,
    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic                  csb0_o,
    output logic                  web0_o,
    output logic [NUM_WMASKS-1:0] wmask0_o,
    output logic [ADDR_WIDTH-1:0] addr0_o,
    output logic [DATA_WIDTH-1:0] din0_o,
    input  logic [DATA_WIDTH-1:0] dout0_i,
    output logic                  csb1_o,
    output logic [ADDR_WIDTH-1:0] addr1_o,
    input  logic [DATA_WIDTH-1:0] dout1_i
);
    localparam int NUM_PORTS = 2;

    logic [NUM_PORTS-1:0]                 issue, credit, rvalid, rready;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] dout, rdata;
    logic                                 a_acc, b_acc, collide;

    logic                  csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;

    // Same-edge write/read to one word has undefined macro ordering, so B waits a cycle.
    assign collide   = a_valid_i & a_we_i & credit[0] & (a_addr_i == b_addr_i);
    assign a_ready_o = credit[0];
    assign b_ready_o = credit[1] & ~collide;
    assign a_acc     = a_valid_i & a_ready_o;
    assign b_acc     = b_valid_i & b_ready_o;

    assign issue  = {b_acc, a_acc & ~a_we_i};
    assign dout   = {dout1_i, dout0_i};
    assign rready = {b_rready_i, a_rready_i};

    assign a_rvalid_o = rvalid[0];
    assign a_rdata_o  = rdata[0];
    assign b_rvalid_o = rvalid[1];
    assign b_rdata_o  = rdata[1];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        sram_1rw1r_32_256_8_rsp #(
            .DATA_WIDTH(DATA_WIDTH),
            .RSP_DEPTH (RSP_DEPTH)
        ) u_rsp (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .rd_issue_i(issue[p]),
            .dout_i    (dout[p]),
            .rready_i  (rready[p]),
            .rvalid_o  (rvalid[p]),
            .rdata_o   (rdata[p]),
            .credit_o  (credit[p])
        );
    end

    always_comb begin
        csb0_d   = 1'b1;
        web0_d   = web0_q;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        csb1_d   = 1'b1;
        addr1_d  = addr1_q;
        if (a_acc) begin
            csb0_d   = 1'b0;
            web0_d   = ~a_we_i;
            addr0_d  = a_addr_i;
            wmask0_d = a_we_i ? a_wmask_i : '0;
            if (a_we_i) din0_d = a_wdata_i;
        end
        if (b_acc) begin
            csb1_d  = 1'b0;
            addr1_d = b_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
            csb1_q   <= 1'b1;
            addr1_q  <= '0;
        end else begin
            csb0_q   <= csb0_d;
            web0_q   <= web0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            din0_q   <= din0_d;
            csb1_q   <= csb1_d;
            addr1_q  <= addr1_d;
        end
    end

    assign csb0_o   = csb0_q;
    assign web0_o   = web0_q;
    assign wmask0_o = wmask0_q;
    assign addr0_o  = addr0_q;
    assign din0_o   = din0_q;
    assign csb1_o   = csb1_q;
    assign addr1_o  = addr1_q;
endmodule

// File: tb/tb_sram_1rw1r_32_256_8_ctrl.sv
// Bench for sram_1rw1r_32_256_8_ctrl: behavioural macro, word-level memory model and
// per-port expected-response queues, plus directed scenarios and a random mix.

module tb_sram_1rw1r_32_256_8_ctrl;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NW = 4;

    logic          clk_i = 1'b0, rst_ni = 1'b0;
    logic          a_valid_i = 0, a_we_i = 0, a_rready_i = 1, b_valid_i = 0, b_rready_i = 1;
    logic [NW-1:0] a_wmask_i = '0;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic [DW-1:0] a_wdata_i = '0;
    logic          a_ready_o, a_rvalid_o, b_ready_o, b_rvalid_o;
    logic [DW-1:0] a_rdata_o, b_rdata_o;
    logic          csb0_o, web0_o, csb1_o;
    logic [NW-1:0] wmask0_o;
    logic [AW-1:0] addr0_o, addr1_o;
    logic [DW-1:0] din0_o, dout0_i = '0, dout1_i = '0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    sram_1rw1r_32_256_8_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_we_i(a_we_i), .a_wmask_i(a_wmask_i),
        .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o),
        .a_rready_i(a_rready_i), .a_rdata_o(a_rdata_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i),
        .b_rvalid_o(b_rvalid_o), .b_rready_i(b_rready_i), .b_rdata_o(b_rdata_o),
        .csb0_o(csb0_o), .web0_o(web0_o), .wmask0_o(wmask0_o), .addr0_o(addr0_o),
        .din0_o(din0_o), .dout0_i(dout0_i), .csb1_o(csb1_o), .addr1_o(addr1_o),
        .dout1_i(dout1_i)
    );

    always #5 clk_i = ~clk_i;

    // Macro: controls latched on the rising edge, array accessed on the falling edge.
    logic [DW-1:0] mem [256] = '{default: '0};
    logic          m_csb0 = 1'b1, m_web0 = 1'b1, m_csb1 = 1'b1;
    logic [NW-1:0] m_wmask0 = '0;
    logic [AW-1:0] m_addr0 = '0, m_addr1 = '0;
    logic [DW-1:0] m_din0 = '0;

    always @(posedge clk_i) begin
        m_csb0 <= csb0_o; m_web0 <= web0_o; m_wmask0 <= wmask0_o;
        m_addr0 <= addr0_o; m_din0 <= din0_o; m_csb1 <= csb1_o; m_addr1 <= addr1_o;
    end

    always @(negedge clk_i) begin
        if (!m_csb0 && !m_web0)
            for (int i = 0; i < NW; i++)
                if (m_wmask0[i]) mem[m_addr0][8*i +: 8] <= m_din0[8*i +: 8];
        if (!m_csb0 && m_web0) dout0_i <= mem[m_addr0];
        if (!m_csb1) dout1_i <= mem[m_addr1];
    end

    // Reference: word memory updated at acceptance; each accepted read queues its expected word.
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];

    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                qa.delete();
                qb.delete();
            end else begin
                if (a_rvalid_o && a_rready_i) begin
                    chk_cnt++;
                    if (qa.size() == 0) $display("FAIL a_rsp_unexpected: got %h want none", a_rdata_o);
                    else begin
                        e = qa.pop_front();
                        if (a_rdata_o !== e) $display("FAIL a_rsp_data: got %h want %h", a_rdata_o, e);
                        else pass_cnt++;
                    end
                end
                if (b_rvalid_o && b_rready_i) begin
                    chk_cnt++;
                    if (qb.size() == 0) $display("FAIL b_rsp_unexpected: got %h want none", b_rdata_o);
                    else begin
                        e = qb.pop_front();
                        if (b_rdata_o !== e) $display("FAIL b_rsp_data: got %h want %h", b_rdata_o, e);
                        else pass_cnt++;
                    end
                end
                if (a_valid_i && a_ready_o && !a_we_i) qa.push_back(ref_mem[a_addr_i]);
                if (b_valid_i && b_ready_o) qb.push_back(ref_mem[b_addr_i]);
                if (a_valid_i && a_ready_o && a_we_i)
                    for (int i = 0; i < NW; i++)
                        if (a_wmask_i[i]) ref_mem[a_addr_i][8*i +: 8] = a_wdata_i[8*i +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        a_valid_i = 0;
        b_valid_i = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        repeat (2) begin
            a_valid_i = 1'($urandom); a_we_i = 1'($urandom); a_wmask_i = NW'($urandom);
            a_addr_i = AW'($urandom); a_wdata_i = $urandom; b_valid_i = 1'($urandom);
            b_addr_i = AW'($urandom); a_rready_i = 1'($urandom); b_rready_i = 1'($urandom);
            tick();
        end
        chk_cnt++; if (csb0_o !== 1'b1) $display("FAIL rst_csb0: got %b want 1", csb0_o); else pass_cnt++;
        chk_cnt++; if (csb1_o !== 1'b1) $display("FAIL rst_csb1: got %b want 1", csb1_o); else pass_cnt++;
        chk_cnt++; if (web0_o !== 1'b1) $display("FAIL rst_web0: got %b want 1", web0_o); else pass_cnt++;
        chk_cnt++; if (wmask0_o !== 4'h0) $display("FAIL rst_wmask0: got %h want 0", wmask0_o); else pass_cnt++;
        chk_cnt++; if ({addr0_o, addr1_o, din0_o} !== '0)
            $display("FAIL rst_addr_din: got %h/%h/%h want 0", addr0_o, addr1_o, din0_o); else pass_cnt++;
        chk_cnt++; if ({a_rvalid_o, b_rvalid_o} !== 2'b00)
            $display("FAIL rst_rvalid: got %b%b want 00", a_rvalid_o, b_rvalid_o); else pass_cnt++;
        chk_cnt++; if ({a_rdata_o, b_rdata_o} !== '0)
            $display("FAIL rst_rdata: got %h/%h want 0", a_rdata_o, b_rdata_o); else pass_cnt++;
        idle(); a_rready_i = 1; b_rready_i = 1; rst_ni = 1;
        #1;
        chk_cnt++; if ({a_ready_o, b_ready_o} !== 2'b11)
            $display("FAIL rst_ready: got %b%b want 11", a_ready_o, b_ready_o); else pass_cnt++;
    endtask

    task automatic test_write_read();
        a_valid_i = 1; a_we_i = 1; a_addr_i = 8'h10; a_wdata_i = 32'hDEADBEEF; a_wmask_i = 4'hF;
        tick();
        chk_cnt++; if ({csb0_o, web0_o, wmask0_o, addr0_o, din0_o} !== {1'b0, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF})
            $display("FAIL wr_pins: got %b %b %h %h %h want 0 0 f 10 deadbeef",
                     csb0_o, web0_o, wmask0_o, addr0_o, din0_o); else pass_cnt++;
        a_we_i = 0;
        tick();
        a_valid_i = 0;
        chk_cnt++; if ({csb0_o, web0_o, wmask0_o, din0_o} !== {1'b0, 1'b1, 4'h0, 32'hDEADBEEF})
            $display("FAIL rd_pins: got %b %b %h %h want 0 1 0 deadbeef",
                     csb0_o, web0_o, wmask0_o, din0_o); else pass_cnt++;
        chk_cnt++; if (a_rvalid_o !== 1'b0) $display("FAIL rd_lat_e1: got %b want 0", a_rvalid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (csb0_o !== 1'b1) $display("FAIL csb0_pulse: got %b want 1", csb0_o); else pass_cnt++;
        chk_cnt++; if (a_rvalid_o !== 1'b0) $display("FAIL rd_lat_e2: got %b want 0", a_rvalid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (a_rvalid_o !== 1'b1) $display("FAIL rd_lat_e3: got %b want 1", a_rvalid_o); else pass_cnt++;
        chk_cnt++; if (a_rdata_o !== 32'hDEADBEEF)
            $display("FAIL rd_data: got %h want deadbeef", a_rdata_o); else pass_cnt++;
        tick();
        chk_cnt++; if (a_rvalid_o !== 1'b0) $display("FAIL rd_popped: got %b want 0", a_rvalid_o); else pass_cnt++;
    endtask

    task automatic test_byte_mask();
        bit got = 0;
        a_valid_i = 1; a_we_i = 1; a_addr_i = 8'h20; a_wdata_i = 32'h11223344; a_wmask_i = 4'hF;
        tick();
        a_wdata_i = 32'hAABBCCDD; a_wmask_i = 4'b0101;
        tick();
        a_valid_i = 0; b_valid_i = 1; b_addr_i = 8'h20;
        tick();
        b_valid_i = 0;
        for (int k = 0; k < 10; k++) begin
            if (b_rvalid_o) begin got = 1; break; end
            tick();
        end
        chk_cnt++;
        if (!got) $display("FAIL mask_timeout: got no b_rvalid want b_rvalid");
        else if (b_rdata_o !== 32'h11BB33DD) $display("FAIL mask_data: got %h want 11bb33dd", b_rdata_o);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        for (int i = 0; i < 8; i++) begin
            a_valid_i = 1; a_we_i = 0; a_addr_i = AW'($urandom_range(0, 255));
            b_valid_i = 1; b_addr_i = AW'($urandom_range(0, 255));
            #1;
            if (!a_ready_o || !b_ready_o) stalls++;
            tick();
        end
        idle();
        chk_cnt++; if (stalls != 0) $display("FAIL b2b_throughput: got %0d stalls want 0", stalls); else pass_cnt++;
        repeat (5) tick();
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] addrs [6];
        int acc = 0;
        foreach (addrs[i]) addrs[i] = AW'($urandom_range(0, 255));
        b_rready_i = 0;
        for (int c = 0; c < 8; c++) begin
            b_valid_i = acc < 6; b_addr_i = addrs[acc < 6 ? acc : 5];
            #1;
            if (b_valid_i && b_ready_o) acc++;
            tick();
        end
        b_valid_i = 1; b_addr_i = addrs[acc < 6 ? acc : 5];
        #1;
        chk_cnt++; if (acc != 4) $display("FAIL bp_accepted: got %0d want 4", acc); else pass_cnt++;
        chk_cnt++; if ({b_ready_o, b_rvalid_o} !== 2'b01)
            $display("FAIL bp_flags: got ready=%b rvalid=%b want ready=0 rvalid=1", b_ready_o, b_rvalid_o);
        else pass_cnt++;
        b_rready_i = 1;
        for (int c = 0; c < 20 && acc < 6; c++) begin
            b_valid_i = 1; b_addr_i = addrs[acc];
            #1;
            if (b_ready_o) acc++;
            tick();
        end
        b_valid_i = 0;
        chk_cnt++; if (acc != 6) $display("FAIL bp_rest: got %0d want 6", acc); else pass_cnt++;
        for (int c = 0; c < 20 && (b_rvalid_o || qb.size() != 0); c++) tick();
        chk_cnt++; if (qb.size() != 0) $display("FAIL bp_drain: got %0d pending want 0", qb.size()); else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [DW-1:0] d = $urandom;
        bit got = 0;
        a_valid_i = 1; a_we_i = 1; a_addr_i = 8'h05; a_wdata_i = d; a_wmask_i = 4'hF;
        b_valid_i = 1; b_addr_i = 8'h05;
        #1;
        chk_cnt++; if ({a_ready_o, b_ready_o} !== 2'b10)
            $display("FAIL coll_ready: got a=%b b=%b want a=1 b=0", a_ready_o, b_ready_o); else pass_cnt++;
        tick();
        a_valid_i = 0;
        #1;
        chk_cnt++; if (b_ready_o !== 1'b1) $display("FAIL coll_next: got %b want 1", b_ready_o); else pass_cnt++;
        tick();
        b_valid_i = 0;
        for (int k = 0; k < 10; k++) begin
            if (b_rvalid_o) begin got = 1; break; end
            tick();
        end
        chk_cnt++;
        if (!got) $display("FAIL coll_timeout: got no b_rvalid want b_rvalid");
        else if (b_rdata_o !== d) $display("FAIL coll_data: got %h want %h", b_rdata_o, d);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        a_valid_i = 1; a_we_i = 0; a_addr_i = 8'h10; b_valid_i = 1; b_addr_i = 8'h20;
        tick();
        idle();
        rst_ni = 0;
        tick();
        tick();
        rst_ni = 1;
        for (int k = 0; k < 6; k++) begin
            if (a_rvalid_o || b_rvalid_o) seen++;
            tick();
        end
        chk_cnt++; if (seen != 0) $display("FAIL rst_mid_rvalid: got %0d cycles want 0", seen); else pass_cnt++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            a_valid_i = 1'($urandom); a_we_i = 1'($urandom); a_addr_i = AW'($urandom_range(0, 7));
            a_wdata_i = $urandom; a_wmask_i = NW'($urandom);
            b_valid_i = 1'($urandom); b_addr_i = AW'($urandom_range(0, 7));
            a_rready_i = $urandom_range(0, 3) != 0; b_rready_i = $urandom_range(0, 3) != 0;
            #1;
            if (a_valid_i && a_we_i && a_ready_o && b_valid_i && a_addr_i == b_addr_i && b_ready_o) bad++;
            tick();
        end
        idle(); a_rready_i = 1; b_rready_i = 1;
        chk_cnt++; if (bad != 0) $display("FAIL rand_collision: got %0d b accepts want 0", bad); else pass_cnt++;
        for (int c = 0; c < 20 && (a_rvalid_o || b_rvalid_o || qa.size() != 0 || qb.size() != 0); c++) tick();
        chk_cnt++; if (qa.size() + qb.size() != 0)
            $display("FAIL rand_drain: got %0d/%0d pending want 0/0", qa.size(), qb.size()); else pass_cnt++;
        chk_cnt++; if ({a_rvalid_o, b_rvalid_o} !== 2'b00)
            $display("FAIL rand_idle: got %b%b want 00", a_rvalid_o, b_rvalid_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_back_to_back();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
